// File: rtl/mem_arbiter_if.sv
// Purpose : bundles the icache, dcache and RAM-side signals of the memory arbiter.
// Latency : none (wires only).
// Backpress: requesters hold their request lines until their wait output drops.
// Ports   : slave  = arbiter view (requests/RAM status in, waits/loads/RAM drive out)
//           master = requester/RAM view (mirror of slave)
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;

    logic        memerr;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose : arbitrates one RAM port between icache and dcache, dcache-first with an
//           anti-starvation limit for icache and a serve-state timeout.
// Latency : 2 cycles minimum (grant in IDLE, completion in first serve cycle on ramready).
// Backpress: a requester's wait stays high until its completion cycle; RAM stalls via ramready.
// Ports   : CLK/RST (async active-high), bus = mem_arbiter_if.slave carrying
//           iREN/iaddr/iwait/iload, dREN/dWEN/daddr/dstore/dwait/dload,
//           ramREN/ramWEN/ramaddr/ramstore/ramload/ramready and memerr.
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
);

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    // Serve counter only needs to reach TIMEOUT-1: it counts serve cycles already spent.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [31:0]   ERR_WORD   = 32'hBAD1_BAD1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DSERVE = 2'd1,
        ISERVE = 2'd2
    } state_t;

    state_t        state_q,  state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [31:0]   addr_q,   addr_d;
    logic [31:0]   store_q,  store_d;
    logic          wr_q,     wr_d;

    logic d_req;
    logic srv_d;
    logic srv_i;
    logic tmo;
    logic fin;

    // A serve state only drives the RAM while its requester still holds a request, so
    // a dropped request removes the enables in the same cycle and cannot complete.
    assign d_req = bus.dREN | bus.dWEN;
    assign srv_d = (state_q == DSERVE) && d_req;
    assign srv_i = (state_q == ISERVE) && bus.iREN;

    // Cycle with cnt_q == TIMEOUT-1 is the last allowed serve cycle; ramready wins there.
    assign tmo = !bus.ramready && (cnt_q == CNT_LAST);
    assign fin = bus.ramready || tmo;

    // Completion outputs are combinational: the wait must drop in the very cycle the
    // RAM reports ramready, so they cannot come from a flop.
    assign bus.iwait  = !(srv_i && fin);
    assign bus.dwait  = !(srv_d && fin);
    assign bus.iload  = (srv_i && bus.ramready) ? bus.ramload :
                        (srv_i && tmo)          ? ERR_WORD    : 32'h0;
    assign bus.dload  = (srv_d && bus.ramready) ? (wr_q ? 32'h0 : bus.ramload) :
                        (srv_d && tmo)          ? ERR_WORD                     : 32'h0;
    assign bus.memerr = (srv_i || srv_d) && tmo;

    assign bus.ramREN   = srv_i || (srv_d && !wr_q);
    assign bus.ramWEN   = srv_d && wr_q;
    assign bus.ramaddr  = (srv_i || srv_d) ? addr_q  : 32'h0;
    assign bus.ramstore = (srv_i || srv_d) ? store_q : 32'h0;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        store_d  = store_q;
        wr_d     = wr_q;

        case (state_q)
            IDLE: begin
                if (bus.iREN && (starve_q == STARVE_LIM || !d_req)) begin
                    // icache wins when starved, or simply when dcache is quiet.
                    state_d  = ISERVE;
                    addr_d   = bus.iaddr;
                    store_d  = 32'h0;
                    wr_d     = 1'b0;
                    cnt_d    = '0;
                    starve_d = '0;
                end else if (d_req) begin
                    state_d  = DSERVE;
                    addr_d   = bus.daddr;
                    store_d  = bus.dstore;
                    wr_d     = bus.dWEN;
                    cnt_d    = '0;
                    // Reaching here with iREN high implies starve_q < STARVE_LIM.
                    starve_d = bus.iREN ? starve_q + SW'(1) : '0;
                end else begin
                    starve_d = '0;
                end
            end

            DSERVE, ISERVE: begin
                if (!(srv_d || srv_i) || fin) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            cnt_q    <= '0;
            addr_q   <= 32'h0;
            store_q  <= 32'h0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wr_q     <= wr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed self-checking bench for mem_arbiter with a completion scoreboard.
// Latency : expected completion cycle is recorded per access and checked by the monitor.
// Backpress: RAM stall is modelled by holding ramready low for chosen cycles.
module tb_mem_arbiter;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_MAX(4),
        .TIMEOUT   (15)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit          is_d;
        logic [31:0] load;
        bit          err;
        logic [31:0] addr;
        bit          ren;
        bit          wen;
        logic [31:0] store;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_inputs();
        bus.iREN     = 1'b0;
        bus.iaddr    = 32'h0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'h0;
        bus.dstore   = 32'h0;
        bus.ramload  = 32'h0;
        bus.ramready = 1'b0;
    endtask

    task automatic expect_done(input bit is_d, input logic [31:0] load, input bit err,
                               input logic [31:0] addr, input bit ren, input bit wen,
                               input logic [31:0] store, input int lat);
        exp_t e;
        e.is_d  = is_d;
        e.load  = load;
        e.err   = err;
        e.addr  = addr;
        e.ren   = ren;
        e.wen   = wen;
        e.store = store;
        e.cyc   = cyc + lat;
        sb.push_back(e);
    endtask

    // Monitor: any wait low or memerr high is a completion and must match the scoreboard.
    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            if (bus.iwait === 1'b0 || bus.dwait === 1'b0 || bus.memerr === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'({bus.iwait, bus.dwait, bus.memerr}), 64'(3'b110));
                end else begin
                    mon_e = sb.pop_front();
                    check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                    check("wait_pair", 64'({bus.iwait, bus.dwait}), mon_e.is_d ? 64'(2'b10) : 64'(2'b01));
                    check("load", mon_e.is_d ? 64'(bus.dload) : 64'(bus.iload), 64'(mon_e.load));
                    check("other_load", mon_e.is_d ? 64'(bus.iload) : 64'(bus.dload), 64'(0));
                    check("memerr", 64'(bus.memerr), 64'(mon_e.err));
                    check("ramaddr", 64'(bus.ramaddr), 64'(mon_e.addr));
                    check("ramREN", 64'(bus.ramREN), 64'(mon_e.ren));
                    check("ramWEN", 64'(bus.ramWEN), 64'(mon_e.wen));
                    check("ramstore", 64'(bus.ramstore), 64'(mon_e.store));
                end
            end else begin
                check("idle_loads", 64'({bus.iload, bus.dload}), 64'(0));
            end
        end
    end

    initial begin
        int lows;

        // Reset with busy-looking inputs: outputs must still sit at reset values.
        RST = 1'b1;
        clear_inputs();
        bus.iREN     = 1'b1;
        bus.dREN     = 1'b1;
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h1234_5678;
        bus.ramready = 1'b1;
        bus.ramload  = 32'hFFFF_FFFF;
        #12;
        check("rst_iwait",   64'(bus.iwait),   64'(1));
        check("rst_dwait",   64'(bus.dwait),   64'(1));
        check("rst_iload",   64'(bus.iload),   64'(0));
        check("rst_dload",   64'(bus.dload),   64'(0));
        check("rst_ramREN",  64'(bus.ramREN),  64'(0));
        check("rst_ramWEN",  64'(bus.ramWEN),  64'(0));
        check("rst_ramaddr", 64'(bus.ramaddr), 64'(0));
        check("rst_memerr",  64'(bus.memerr),  64'(0));
        clear_inputs();
        tick();
        RST = 1'b0;
        tick();

        // icache read, RAM ready on first serve cycle.
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h40;
        expect_done(1'b0, 32'h1234, 1'b0, 32'h40, 1'b1, 1'b0, 32'h0, 1);
        @(negedge CLK);
        check("i_c0_ramREN", 64'(bus.ramREN), 64'(0));
        tick();
        bus.ramready = 1'b1;
        bus.ramload  = 32'h1234;
        tick();
        clear_inputs();
        @(negedge CLK);
        check("i_c2_ramREN", 64'(bus.ramREN), 64'(0));
        tick();

        // Simultaneous icache read and dcache write: dcache first, icache next grant.
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h44;
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h80;
        bus.dstore   = 32'hCAFE;
        bus.ramready = 1'b1;
        bus.ramload  = 32'h5555;
        expect_done(1'b1, 32'h0,    1'b0, 32'h80, 1'b0, 1'b1, 32'hCAFE, 1);
        expect_done(1'b0, 32'h5555, 1'b0, 32'h44, 1'b1, 1'b0, 32'h0,    3);
        ticks(2);
        bus.dWEN = 1'b0;
        ticks(2);
        clear_inputs();
        tick();

        // Starvation limit: 4 dcache grants, 1 icache grant, then dcache again.
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h48;
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h90;
        bus.ramready = 1'b1;
        bus.ramload  = 32'hD00D;
        for (int k = 0; k < 4; k++)
            expect_done(1'b1, 32'hD00D, 1'b0, 32'h90, 1'b1, 1'b0, 32'h0, 1 + 2 * k);
        expect_done(1'b0, 32'hD00D, 1'b0, 32'h48, 1'b1, 1'b0, 32'h0, 9);
        expect_done(1'b1, 32'hD00D, 1'b0, 32'h90, 1'b1, 1'b0, 32'h0, 11);
        ticks(12);
        clear_inputs();
        tick();

        // dcache read with two RAM stall cycles.
        bus.dREN  = 1'b1;
        bus.daddr = 32'h300;
        expect_done(1'b1, 32'hABCD_0123, 1'b0, 32'h300, 1'b1, 1'b0, 32'h0, 3);
        ticks(2);
        @(negedge CLK);
        check("stall_dwait",  64'(bus.dwait),  64'(1));
        check("stall_ramREN", 64'(bus.ramREN), 64'(1));
        tick();
        bus.ramready = 1'b1;
        bus.ramload  = 32'hABCD_0123;
        tick();
        clear_inputs();
        tick();

        // icache drops its request mid-service: abort, then dcache is granted from IDLE.
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h500;
        tick();
        @(negedge CLK);
        check("abort_c1_ramREN",  64'(bus.ramREN),  64'(1));
        check("abort_c1_ramaddr", 64'(bus.ramaddr), 64'(32'h500));
        tick();
        bus.iREN     = 1'b0;
        bus.ramready = 1'b1;
        bus.ramload  = 32'h99;
        @(negedge CLK);
        check("abort_ramREN",  64'(bus.ramREN),  64'(0));
        check("abort_ramaddr", 64'(bus.ramaddr), 64'(0));
        check("abort_iwait",   64'(bus.iwait),   64'(1));
        tick();
        bus.dREN  = 1'b1;
        bus.daddr = 32'h600;
        expect_done(1'b1, 32'h99, 1'b0, 32'h600, 1'b1, 1'b0, 32'h0, 1);
        ticks(2);
        clear_inputs();
        tick();

        // Timeout: ramready never arrives; error on the 15th serve cycle, then IDLE.
        bus.dREN  = 1'b1;
        bus.daddr = 32'h100;
        expect_done(1'b1, 32'hBAD1_BAD1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 15);
        ticks(16);
        @(negedge CLK);
        check("tmo_idle_ramREN", 64'(bus.ramREN), 64'(0));
        tick();
        clear_inputs();
        ticks(2);

        // Reset pulsed during DSERVE: outputs drop at once, no completion after release.
        bus.dREN  = 1'b1;
        bus.daddr = 32'h200;
        tick();
        @(negedge CLK);
        check("rst_mid_pre_ramREN", 64'(bus.ramREN), 64'(1));
        #2;
        RST = 1'b1;
        #1;
        check("rst_mid_ramREN",  64'(bus.ramREN),  64'(0));
        check("rst_mid_ramaddr", 64'(bus.ramaddr), 64'(0));
        check("rst_mid_dwait",   64'(bus.dwait),   64'(1));
        check("rst_mid_dload",   64'(bus.dload),   64'(0));
        check("rst_mid_memerr",  64'(bus.memerr),  64'(0));
        bus.dREN = 1'b0;
        ticks(2);
        RST          = 1'b0;
        bus.ramready = 1'b1;
        bus.ramload  = 32'h42;
        lows = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (bus.dwait !== 1'b1) lows++;
        end
        check("rst_no_done", 64'(lows), 64'(0));
        tick();
        clear_inputs();
        ticks(3);

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
